// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state
// encodings and system register numbers used by processor decode.
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_SVC  = 2'b10
    } intr_state_t;

    // System register numbers, shared with the processor decode.
    localparam logic [1:0] SREG_SCS = 2'd0;
    localparam logic [1:0] SREG_SIH = 2'd1;
    localparam logic [1:0] SREG_SRA = 2'd2;
    localparam logic [1:0] SREG_SII = 2'd3;

    localparam int unsigned NSRC_DEFAULT   = 4;
    localparam int unsigned IDBITS_DEFAULT = 2;
    localparam int unsigned DBITS_DEFAULT  = 16;

endpackage

// File: rtl/intr_ctrl_if.sv
// Interrupt handshake between controller (master) and pipeline (slave).
// Signals: intr_req, intr_id, sii_out, in_service (controller driven),
// intr_ack, reti (pipeline driven pulses).
interface intr_ctrl_if #(
    parameter int IDBITS = 2,
    parameter int DBITS  = 16
) ();
    logic              intr_req;
    logic              intr_ack;
    logic              reti;
    logic [IDBITS-1:0] intr_id;
    logic [DBITS-1:0]  sii_out;
    logic              in_service;

    modport master (
        output intr_req,
        output intr_id,
        output sii_out,
        output in_service,
        input  intr_ack,
        input  reti
    );

    modport slave (
        input  intr_req,
        input  intr_id,
        input  sii_out,
        input  in_service,
        output intr_ack,
        output reti
    );
endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder, lowest set index wins.
// Ports: vec (NSRC request bits) -> idx (winner), valid (any set).
module intr_ctrl_prio_enc #(
    parameter int NSRC   = 4,
    parameter int IDBITS = 2
) (
    input  logic [NSRC-1:0]   vec,
    output logic [IDBITS-1:0] idx,
    output logic              valid
);
    // Scan downward so the lowest set index is the last assignment.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDBITS'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge capture, pending/mask registers and the
// request/acknowledge/return FSM toward the pipeline.
// Ports: clk, reset (sync, active high), irq, ie, mask_we, mask_din,
// pending (raw), bus (intr_ctrl_if.master handshake).
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NSRC   = 4,
    parameter int IDBITS = 2,
    parameter int DBITS  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic            ie,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_din,
    output logic [NSRC-1:0] pending,
    intr_ctrl_if.master     bus
);
    intr_state_t       state;
    logic [NSRC-1:0]   irq_q;
    logic [NSRC-1:0]   pend_q;
    logic [NSRC-1:0]   mask;
    logic [NSRC-1:0]   irq_edge;
    logic [NSRC-1:0]   eligible;
    logic [NSRC-1:0]   ack_clr;
    logic [IDBITS-1:0] intr_id_q;
    logic [IDBITS-1:0] win_id;
    logic              win_valid;
    logic              req_q;
    logic              svc_q;

    assign irq_edge = irq & ~irq_q;
    assign eligible = pend_q & mask;

    // Only an acknowledge taken in REQ retires the pending bit.
    always_comb begin
        ack_clr = '0;
        if (state == ST_REQ && bus.intr_ack)
            ack_clr[intr_id_q] = 1'b1;
    end

    intr_ctrl_prio_enc #(
        .NSRC   (NSRC),
        .IDBITS (IDBITS)
    ) u_prio (
        .vec   (eligible),
        .idx   (win_id),
        .valid (win_valid)
    );

    // irq_q resets high so lines already asserted never look like edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q  <= '1;
            pend_q <= '0;
            mask   <= '0;
        end else begin
            irq_q  <= irq;
            pend_q <= (pend_q & ~ack_clr) | irq_edge;
            if (mask_we)
                mask <= mask_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            intr_id_q <= '0;
            req_q     <= 1'b0;
            svc_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ie && win_valid) begin
                        state     <= ST_REQ;
                        req_q     <= 1'b1;
                        intr_id_q <= win_id;
                    end
                end
                ST_REQ: begin
                    if (bus.intr_ack) begin
                        state <= ST_SVC;
                        req_q <= 1'b0;
                        svc_q <= 1'b1;
                    end else if (!ie || !mask[intr_id_q]) begin
                        state <= ST_IDLE;
                        req_q <= 1'b0;
                    end
                end
                ST_SVC: begin
                    if (bus.reti) begin
                        state <= ST_IDLE;
                        svc_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                    svc_q <= 1'b0;
                end
            endcase
        end
    end

    assign pending        = pend_q;
    assign bus.intr_req   = req_q;
    assign bus.in_service = svc_q;
    assign bus.intr_id    = intr_id_q;
    assign bus.sii_out    = {{(DBITS-IDBITS){1'b0}}, intr_id_q};
endmodule
